sobel_pixel_pipeline: RTL
=========================

SOBEL_PIXEL_PIPELINE -- requirements
Module: sobel_pixel_pipeline

Interface
REQ-001 SHALL have parameters: H_PIXELS 960, visible columns; V_LINES 720, visible lines; SCALE 3, display-to-source upscale factor; SRC_W 320, source width; SRC_H 240, source height; ADDR_W 17, frame memory address width.
REQ-002 SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-003 SHALL have ports: clk in 1, pixel clock; rst in 1, async reset.
REQ-004 h_cnt in 11 and v_cnt in 10, raw timing counters; display_area, hsync_in, vsync_in in 1 each, registered timing flags lagging the counters by one cycle.
REQ-005 mem_addr out ADDR_W, frame memory read address; mem_data in 8, grayscale pixel returned one cycle after mem_addr (synchronous BRAM).
REQ-006 mode in 2, output select; threshold in 8, binary edge threshold.
REQ-007 vga_r, vga_g, vga_b out 4 each, pixel colour; vga_hs, vga_vs out 1 each, syncs aligned to the colour outputs.

Function
REQ-008 SHALL register mem_addr = (v_cnt/SCALE)*SRC_W + (h_cnt/SCALE), integer division; for a counter value at cycle t, the address is valid at t+1 and the data at t+2.
REQ-009 SHALL clamp the address to 0 when h_cnt >= H_PIXELS or v_cnt >= V_LINES.
REQ-010 SHALL delay display_area, hsync_in, and vsync_in by 4 cycles, so the colour output for counter value (H,V) appears at t+5 with its own sync and valid flags.
REQ-011 SHALL keep col (0..H_PIXELS-1) and row (0..V_LINES-1) counters at the pixel stage; col increments per valid pixel and clears when valid deasserts; row increments at each valid-line end and clears while vsync_in is low.
REQ-012 SHALL keep two H_PIXELS x 8 line buffers; each valid pixel is written at index col, and the older line is shifted in.
REQ-013 SHALL keep a 3x3 window whose bottom-right element is the current pixel, so the window is centred at (col-1,row-1).
REQ-014 SHALL compute Gx = (right column) - (left column), weights 1,2,1; Gy = (bottom row) - (top row), weights 1,2,1; both 11-bit signed, with no overflow for range +/-1020.
REQ-015 SHALL compute mag = |Gx| + |Gy| (12 bit), saturated to 8 bits: 255 when mag > 255.
REQ-016 SHALL force mag to 0 when col < 2 or row < 2 (incomplete window).
REQ-017 SHALL select output by mode: 0 = grayscale passthrough of pixel (H,V), giving {pix[7:4]} on r, g, and b; 1 = mag[7:4] on r, g, and b; 2 = F,F,F when mag >= threshold, else 0; 3 = inverse of mode 2.
REQ-018 SHALL sample mode and threshold only on the falling edge of vsync_in; changes mid-frame take effect next frame.
REQ-019 SHALL drive RGB = 0 whenever the delayed display_area = 0, regardless of mode.
REQ-020 SHALL stay stall-free: one pixel per clock, no backpressure.

Reset
REQ-021 While rst = 1: vga_r, vga_g, vga_b = 0; vga_hs = vga_vs = 1; mem_addr = 0; all delay-line sync stages = 1; all valid stages = 0; col = row = 0; mode register = 0; threshold register = 128.
REQ-022 Line buffer contents SHALL NOT require reset; garbage is masked by REQ-016 for the first two rows.
REQ-023 Assertion of rst mid-frame SHALL take effect immediately (async); after release, the first valid output occurs 5 cycles after counters re-enter the visible area.

Verification
REQ-024 Reset mid-line, then release -> RGB = 0 and hs/vs = 1 during reset; first nonzero output exactly 5 cycles after h_cnt = 0, v_cnt = 0.
REQ-025 h_cnt = 959, v_cnt = 719 -> mem_addr = 76799 next cycle; h = 3, v = 3 -> mem_addr = 321; h = 1000 -> mem_addr = 0.
REQ-026 Mode 0, mem_data constant 0xA7 -> RGB = A,A,A inside the visible area and 0 outside; vga_hs low exactly 4 cycles after hsync_in low and for the same duration.
REQ-027 Mode 1, source pixels 0 for src_x < 100 and 255 otherwise, rows >= 2 -> RGB = F at display cols 300 and 301 (Gx = 1020, saturated) and 0 at all other cols.
REQ-028 Mode 2, threshold 128, same image -> white only at cols 300 and 301; threshold written 255 mid-frame -> unchanged until the next vsync fall, then still white (255 >= 255).
REQ-029 Mode 1, uniform 255 image -> output 0 everywhere, including rows 0-1 and cols 0-1 with uninitialised line buffers.

Source files
------------

// File: rtl/sobel_pixel_pipeline.sv
// sobel_pixel_pipeline: upscaled frame-memory fetch, 3x3 Sobel edge filter and VGA colour select.
// Rev 1.0
`default_nettype none

module sobel_pixel_pipeline #(
  parameter int H_PIXELS = 960,
  parameter int V_LINES  = 720,
  parameter int SCALE    = 3,
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              display_area,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic [1:0]        mode,
  input  logic [7:0]        threshold,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs
);

  localparam int COL_W = $clog2(H_PIXELS);
  localparam int ROW_W = $clog2(V_LINES);
  localparam logic [3:0] FULL = 4'hF;

  // ---------------------------------------------------------------- address
  logic [10:0]       src_x;
  logic [9:0]        src_y;
  logic              in_range;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    src_x     = h_cnt / 11'(SCALE);
    src_y     = v_cnt / 10'(SCALE);
    in_range  = (h_cnt < 11'(H_PIXELS)) && (v_cnt < 10'(V_LINES)) &&
                (src_x < 11'(SRC_W)) && (src_y < 10'(SRC_H));
    addr_next = ADDR_W'(src_y) * ADDR_W'(SRC_W) + ADDR_W'(src_x);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_addr <= '0;
    else     mem_addr <= in_range ? addr_next : '0;
  end

  // ------------------------------------------------------- flag delay lines
  // Stage 1 lines up with mem_data; stage 4 lines up with the colour outputs.
  logic [4:1] valid_d;
  logic [4:1] hs_d;
  logic [4:1] vs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d <= '0;
      hs_d    <= '1;
      vs_d    <= '1;
    end else begin
      valid_d <= {valid_d[3:1], display_area};
      hs_d    <= {hs_d[3:1], hsync_in};
      vs_d    <= {vs_d[3:1], vsync_in};
    end
  end

  assign vga_hs = hs_d[4];
  assign vga_vs = vs_d[4];

  // ----------------------------------------------------- pixel position
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      if (!valid_d[1])                          col <= '0;
      else if (col != COL_W'(H_PIXELS - 1))     col <= col + 1'b1;

      if (!vsync_in)                            row <= '0;
      else if (valid_d[2] && !valid_d[1] && (row != ROW_W'(V_LINES - 1)))
                                                row <= row + 1'b1;
    end
  end

  // ------------------------------------------- line buffers and window
  // Contents are never reset; the incomplete-window mask hides stale data.
  logic [7:0] line_prev  [H_PIXELS];
  logic [7:0] line_prev2 [H_PIXELS];
  logic [7:0] win [3][3];

  always_ff @(posedge clk) begin
    if (valid_d[1]) begin
      line_prev[col]  <= mem_data;
      line_prev2[col] <= line_prev[col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= line_prev2[col];
      win[1][2] <= line_prev[col];
      win[2][2] <= mem_data;
    end
  end

  logic [7:0] pix_d3;
  logic [7:0] pix_d4;
  logic       full_d3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_d3  <= '0;
      pix_d4  <= '0;
      full_d3 <= 1'b0;
    end else begin
      pix_d3  <= mem_data;
      pix_d4  <= pix_d3;
      full_d3 <= (col >= COL_W'(2)) && (row >= ROW_W'(2));
    end
  end

  // ------------------------------------------------------------- Sobel
  function automatic logic signed [10:0] ext(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [10:0]        ax;
  logic [10:0]        ay;
  logic [11:0]        mag;
  logic [7:0]         mag_sat;

  always_comb begin
    gx = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2])
       - ext(win[0][0]) - (ext(win[1][0]) <<< 1) - ext(win[2][0]);
    gy = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2])
       - ext(win[0][0]) - (ext(win[0][1]) <<< 1) - ext(win[0][2]);
    ax      = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    ay      = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag     = {1'b0, ax} + {1'b0, ay};
    mag_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
  end

  logic [7:0] mag_d4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mag_d4 <= '0;
    else     mag_d4 <= full_d3 ? mag_sat : 8'h00;
  end

  // ------------------------------------------------- frame-synchronous controls
  logic       vs_prev;
  logic [1:0] mode_reg;
  logic [7:0] thr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev  <= 1'b1;
      mode_reg <= 2'd0;
      thr_reg  <= 8'd128;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) begin
        mode_reg <= mode;
        thr_reg  <= threshold;
      end
    end
  end

  // --------------------------------------------------------- colour select
  logic [3:0] color;

  always_comb begin
    color = 4'h0;
    case (mode_reg)
      2'd0:    color = pix_d4[7:4];
      2'd1:    color = mag_d4[7:4];
      2'd2:    color = (mag_d4 >= thr_reg) ? FULL : 4'h0;
      default: color = (mag_d4 >= thr_reg) ? 4'h0 : FULL;
    endcase
    if (!valid_d[3]) color = 4'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= color;
      vga_g <= color;
      vga_b <= color;
    end
  end

endmodule

`default_nettype wire
